alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_mul_seq.sv | 52 +++++
 rtl/alu_seq.sv | 120 ++++++++++++
 tb/tb_alu_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential ALU: opcodes and control FSM states.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD   = 3'b000,
      OP_SUB   = 3'b001,
      OP_MUL   = 3'b010,
      OP_ILL   = 3'b011,
      OP_EQ    = 3'b100,
      OP_GT    = 3'b101,
      OP_LT    = 3'b110,
      OP_AZERO = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } state_t;

   function automatic logic is_mul_op(input logic [2:0] op);
      return opcode_t'(op) == OP_MUL;
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: consumes one bit of b per clock, WIDTH iterations after start,
// and returns the low WIDTH bits of the product.
module alu_mul_seq #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic [WIDTH-1:0] w_acc_next;

   // Low WIDTH bits of an unsigned product equal those of the signed product.
   assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign done       = r_busy && (r_cnt == CW'(WIDTH - 1));
   assign product    = w_acc_next;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
      end else if (start) begin
         r_acc    <= '0;
         r_mcand  <= a;
         r_mplier <= b;
         r_cnt    <= '0;
         r_busy   <= 1'b1;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (done) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle add/sub/compare ops and a
// multi-cycle shift-add multiply, one result register held until the consumer takes it.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] C,
   output logic             ovf,
   output logic             err,
   output logic             out_valid,
   input  logic             out_ready
);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_c;
   logic             r_ovf;
   logic             r_err;

   logic             w_accept;
   logic             w_is_mul;
   logic             w_mul_start;
   logic             w_mul_done;
   logic [WIDTH-1:0] w_mul_product;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_alu_c;
   logic             w_alu_ovf;
   logic             w_alu_err;

   // NOTE: in_ready looks at out_ready combinationally so DONE can hand off and accept in one edge.
   assign in_ready    = (r_state == IDLE) || ((r_state == DONE) && out_ready);
   assign out_valid   = (r_state == DONE);
   assign w_accept    = in_valid && in_ready;
   assign w_is_mul    = is_mul_op(sel);
   assign w_mul_start = w_accept && w_is_mul;

   assign C   = r_c;
   assign ovf = r_ovf;
   assign err = r_err;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (w_mul_start),
      .a       (A),
      .b       (B),
      .done    (w_mul_done),
      .product (w_mul_product)
   );

   // NOTE: every output of this block is defaulted first, so no path can infer a latch.
   always_comb begin
      w_sum     = A + B;
      w_diff    = A - B;
      w_alu_c   = '0;
      w_alu_ovf = 1'b0;
      w_alu_err = 1'b0;
      case (opcode_t'(sel))
         OP_ADD: begin
            w_alu_c   = w_sum;
            w_alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            w_alu_c   = w_diff;
            w_alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_ILL:   w_alu_err = 1'b1;
         OP_EQ:    w_alu_c = WIDTH'(A == B);
         OP_GT:    w_alu_c = WIDTH'($signed(A) > $signed(B));
         OP_LT:    w_alu_c = WIDTH'($signed(A) < $signed(B));
         OP_AZERO: w_alu_c = WIDTH'(A == '0);
         default:  ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_next = w_is_mul ? MUL : DONE;
         MUL:  if (w_mul_done) w_state_next = DONE;
         DONE: begin
            if (out_ready) begin
               if (w_accept) w_state_next = w_is_mul ? MUL : DONE;
               else          w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Result register: loaded at accept for single-cycle ops, at the final iteration for multiply.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_c   <= '0;
         r_ovf <= 1'b0;
         r_err <= 1'b0;
      end else if (w_accept) begin
         if (!w_is_mul) r_c <= w_alu_c;
         r_ovf <= w_alu_ovf;
         r_err <= w_alu_err;
      end else if ((r_state == MUL) && w_mul_done) begin
         r_c <= w_mul_product;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed stimulus for alu_seq with a queue scoreboard and an
// independent output monitor driven by an arithmetic reference model.
module tb_alu_seq;

   localparam int W    = 6;
   localparam int SMAX = (1 << (W - 1)) - 1;
   localparam int SMIN = -(1 << (W - 1));

   typedef struct packed {
      logic [W-1:0] c;
      logic         ovf;
      logic         err;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [2:0]   sel;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] C;
   logic         ovf;
   logic         err;
   logic         out_valid;
   logic         out_ready;

   exp_t         exp_q[$];
   int           n_checks;
   int           n_errors;
   logic         rand_ready;
   logic         hold_valid;
   logic [W+1:0] hold_snap;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .C         (C),
      .ovf       (ovf),
      .err       (err),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference model: signed integer arithmetic, wrapped to W bits afterwards.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
      exp_t e;
      int   sa;
      int   sb;
      int   r;
      sa    = int'($signed(a));
      sb    = int'($signed(b));
      r     = 0;
      e.ovf = 1'b0;
      e.err = 1'b0;
      case (s)
         3'd0: begin r = sa + sb; e.ovf = (r > SMAX) || (r < SMIN); end
         3'd1: begin r = sa - sb; e.ovf = (r > SMAX) || (r < SMIN); end
         3'd2: r = sa * sb;
         3'd3: e.err = 1'b1;
         3'd4: r = (sa == sb) ? 1 : 0;
         3'd5: r = (sa > sb) ? 1 : 0;
         3'd6: r = (sa < sb) ? 1 : 0;
         default: r = (sa == 0) ? 1 : 0;
      endcase
      e.c = r[W-1:0];
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Called one time unit after a rising edge; returns one time unit after the accepting edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s);
      int waited;
      A        = a;
      B        = b;
      sel      = s;
      in_valid = 1'b1;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         waited++;
         tick();
         @(negedge clk);
      end
      if (in_ready) begin
         exp_q.push_back(model(a, b, s));
      end else begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, want 1", waited);
      end
      tick();
      in_valid = 1'b0;
      A        = W'($urandom);
      B        = W'($urandom);
      sel      = 3'($urandom);
   endtask

   // Monitor: pops the scoreboard on every transfer and checks that stalled results stay put.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         hold_valid = 1'b0;
      end else begin
         if (hold_valid) check("stall_hold", {out_valid, ovf, err, C}, {1'b1, hold_snap});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_result: got C=%0h ovf=%0b err=%0b, want no output", C, ovf, err);
            end else begin
               e = exp_q.pop_front();
               check("result", {C, ovf, err}, {e.c, e.ovf, e.err});
            end
         end
         hold_valid = out_valid && !out_ready;
         hold_snap  = {ovf, err, C};
      end
   end

   initial begin
      int guard;
      n_checks   = 0;
      n_errors   = 0;
      hold_valid = 1'b0;
      hold_snap  = '0;
      rand_ready = 1'b0;
      rst        = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      A          = '0;
      B          = '0;
      sel        = '0;

      #1 rst = 1'b1;
      #2 check("reset_state", {out_valid, ovf, err, C}, '0);
      #19 rst = 1'b0;
      @(posedge clk);
      #1 check("ready_after_reset", in_ready, 1'b1);

      // Basic add: result one cycle after accept.
      issue(W'(5), W'(10), 3'd0);
      check("add_latency", out_valid, 1'b1);

      // Signed overflow on add and sub, issued back to back.
      issue(W'(31), W'(15), 3'd0);
      issue(W'(16), W'(-18), 3'd1);

      // Multiply: busy for W cycles, result after the last iteration edge.
      issue(W'(7), W'(-3), 3'd2);
      for (int k = 0; k < W; k++) begin
         check("mul_busy", {in_ready, out_valid}, 2'b00);
         tick();
      end
      check("mul_latency", out_valid, 1'b1);
      tick();

      // Consumer stall, then simultaneous hand-off and new accept.
      out_ready = 1'b0;
      issue(W'(20), W'(3), 3'd1);
      for (int k = 0; k < 5; k++) begin
         check("stall_valid", out_valid, 1'b1);
         tick();
      end
      out_ready = 1'b1;
      issue(W'(-3), W'(-10), 3'd5);
      check("no_bubble", out_valid, 1'b1);

      // Reset in the third multiply cycle discards the operation.
      issue(W'(5), W'(3), 3'd2);
      tick();
      tick();
      #2 rst = 1'b1;
      #1 check("reset_async", {out_valid, ovf, err, C}, '0);
      exp_q.delete();
      @(posedge clk);
      #3 rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("no_ghost_result", out_valid, 1'b0);
      end
      tick();

      // A==0 sweep and the illegal opcode.
      for (int a = 0; a < (1 << W); a++) issue(W'(a), W'($urandom), 3'd7);
      issue(W'($urandom), W'($urandom), 3'd3);
      issue(W'(-32), W'(1), 3'd1);
      issue(W'(-32), W'(-32), 3'd4);

      // Random traffic with random consumer back-pressure.
      rand_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         issue(W'($urandom), W'($urandom), 3'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end

      rand_ready = 1'b0;
      out_ready  = 1'b1;
      guard      = 0;
      while ((exp_q.size() != 0 || out_valid) && guard < 100) begin
         tick();
         guard++;
      end
      check("drain_pending", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
